// File: rtl/fs_25_seq_if.sv
// Handshake bundle for the chunked 25-bit subtractor: operand side (in_*) and result side (out_*).
// Ports: in_valid/in_ready + a, b, bin toward the block; out_valid/out_ready + d, bout, zero from it.
// Modports: master is the operand source / result consumer, slave is the subtractor itself.
interface fs_25_seq_if #(
    parameter int DATA_WIDTH = 25
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] d;
    logic                  bout;
    logic                  zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, zero
    );
endinterface

// File: rtl/fs_25_seq.sv
// Multi-cycle subtractor d = a - b - bin, one CHUNK-bit slice per cycle, LSB slice first, borrow rippled.
// Latency: out_valid high NCHUNK cycles after the accept edge; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; ports clk, rst, bus (slave).
module fs_25_seq #(
    parameter int DATA_WIDTH = 25,
    parameter int CHUNK      = 8
) (
    input  logic        clk,
    input  logic        rst,
    fs_25_seq_if.slave  bus
);
    localparam int NCHUNK = (DATA_WIDTH + CHUNK - 1) / CHUNK;
    // Width of the top slice: the remainder, or a full chunk when it divides evenly.
    localparam int LAST_W = DATA_WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  brw;
    logic                  bout_q;
    logic                  zero_q;

    logic                  last;
    logic [CHUNK-1:0]      a_ch;
    logic [CHUNK-1:0]      b_ch;
    logic [CHUNK:0]        diff;
    logic                  brw_nxt;
    logic [DATA_WIDTH-1:0] chunk_mask;
    logic [DATA_WIDTH-1:0] d_nxt;

    // Slice datapath. Shifting the operands down leaves zeros above the
    // valid bits of the top slice, so the same subtractor serves every slice.
    always_comb begin
        last       = (idx == IDX_W'(NCHUNK - 1));
        a_ch       = CHUNK'(a_q >> (idx * CHUNK));
        b_ch       = CHUNK'(b_q >> (idx * CHUNK));
        diff       = {1'b0, a_ch} - {1'b0, b_ch} - {{CHUNK{1'b0}}, brw};
        // On the narrow top slice a negative result sign-fills upward, so bit
        // LAST_W is the borrow out of the valid bits.
        brw_nxt    = last ? diff[LAST_W] : diff[CHUNK];
        chunk_mask = DATA_WIDTH'({CHUNK{1'b1}}) << (idx * CHUNK);
        // Bits shifted past DATA_WIDTH drop off, keeping only the valid top bits.
        d_nxt      = (d_q & ~chunk_mask)
                   | ((DATA_WIDTH'(diff[CHUNK-1:0]) << (idx * CHUNK)) & chunk_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = CALC;
            CALC: if (last)         state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw    <= 1'b0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        brw <= bus.bin;
                        d_q <= '0;
                        idx <= '0;
                    end
                end
                CALC: begin
                    d_q <= d_nxt;
                    brw <= brw_nxt;
                    if (last) begin
                        bout_q <= brw_nxt;
                        zero_q <= (d_nxt == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_fs_25_seq.sv
// Directed bench for fs_25_seq: vector table plus backpressure, back-to-back and mid-operation reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every comparison steps total; mismatches step bad and print one FAIL line.
module tb_fs_25_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fs_25_seq_if #(.DATA_WIDTH(25)) bus ();

    fs_25_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] a;
        logic [24:0] b;
        logic        bin;
        logic [24:0] d;
        logic        bout;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present operands and return at the falling edge just after the accept edge.
    task automatic start_op(input logic [24:0] a, input logic [24:0] b, input logic bin);
        int k;
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        start_op(v.a, v.b, v.bin);
        wait_out(lat);
        check({nm, ".latency"}, 32'(lat), 32'd4);
        check({nm, ".d"},       32'(bus.d), 32'(v.d));
        check({nm, ".bout"},    32'(bus.bout), 32'(v.bout));
        check({nm, ".zero"},    32'(bus.zero), 32'(v.zero));
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({nm, ".drop"},    32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int k;
        int acc1;
        int acc2;
        int seen;

        vecs[0] = '{25'h1000000, 25'h0000001, 1'b0, 25'h0FFFFFF, 1'b0, 1'b0};
        vecs[1] = '{25'h0000000, 25'h0000001, 1'b0, 25'h1FFFFFF, 1'b1, 1'b0};
        vecs[2] = '{25'h0000000, 25'h0000000, 1'b1, 25'h1FFFFFF, 1'b1, 1'b0};
        vecs[3] = '{25'h155AAAA, 25'h155AAAA, 1'b0, 25'h0000000, 1'b0, 1'b1};
        vecs[4] = '{25'h0000000, 25'h1FFFFFF, 1'b1, 25'h0000000, 1'b1, 1'b1};
        vecs[5] = '{25'h0ABCDEF, 25'h0012345, 1'b0, 25'h0AAAAAA, 1'b0, 1'b0};
        vecs[6] = '{25'h0000100, 25'h0000200, 1'b0, 25'h1FFFF00, 1'b1, 1'b0};
        vecs[7] = '{25'h1FFFFFF, 25'h0000000, 1'b1, 25'h1FFFFFE, 1'b0, 1'b0};
        vecs[8] = '{25'h0ABCDEF, 25'h0ABCDEF, 1'b1, 25'h1FFFFFF, 1'b1, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.in_ready",  32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.d",         32'(bus.d), 32'd0);
        check("reset.bout",      32'(bus.bout), 32'd0);
        check("reset.zero",      32'(bus.zero), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, new operands ignored until consumed.
        start_op(25'h0000005, 25'h0000003, 1'b0);
        wait_out(lat);
        check("bp.latency", 32'(lat), 32'd4);
        bus.a        = 25'h0000010;
        bus.b        = 25'h0000001;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.d",         32'(bus.d), 32'h2);
            check("bp.bout",      32'(bus.bout), 32'd0);
            check("bp.zero",      32'(bus.zero), 32'd0);
            check("bp.in_ready",  32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.release_valid", 32'(bus.out_valid), 32'd0);
        check("bp.release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("bp.next_latency", 32'(lat), 32'd4);
        check("bp.next_d",       32'(bus.d), 32'hF);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        bus.a         = 25'h0ABCDEF;
        bus.b         = 25'h0012345;
        bus.bin       = 1'b0;
        bus.in_valid  = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        acc1 = cyc;
        @(posedge clk);
        @(negedge clk);
        bus.a = 25'h0000100;
        bus.b = 25'h0000200;
        wait_out(lat);
        check("b2b.lat1",  32'(lat), 32'd4);
        check("b2b.d1",    32'(bus.d), 32'h0AAAAAA);
        check("b2b.bout1", 32'(bus.bout), 32'd0);
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        acc2 = cyc;
        check("b2b.spacing", 32'(acc2 - acc1), 32'd6);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("b2b.lat2",  32'(lat), 32'd4);
        check("b2b.d2",    32'(bus.d), 32'h1FFFF00);
        check("b2b.bout2", 32'(bus.bout), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset during the second CALC cycle aborts the operation.
        start_op(25'h1234567, 25'h0000567, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.in_ready",  32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.d",         32'(bus.d), 32'd0);
        check("rst.bout",      32'(bus.bout), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst.no_result", 32'(seen), 32'd0);
        run_vec(vecs[5], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
